// File: rtl/lpn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lpn_pkg
// Description : Shared constants and FSM state encoding for the LPN multiplier
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lpn_pkg;

   localparam int LPN_N = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_EVAL1 = 2'b01,
      ST_EVAL2 = 2'b10,
      ST_DONE  = 2'b11
   } lpn_state_e;

endpackage
`default_nettype wire

// File: rtl/lpn_mul_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lpn_mul_ctrl_if
// Description : Job/result handshakes plus the operand/result path to the
//               GF(2) matrix-vector multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface lpn_mul_ctrl_if;

   logic                                         in_valid;
   logic                                         in_ready;
   logic [lpn_pkg::LPN_N*lpn_pkg::LPN_N-1:0]     in_a;
   logic [lpn_pkg::LPN_N-1:0]                    in_b;
   logic [lpn_pkg::LPN_N-1:0]                    in_e;
   logic [lpn_pkg::LPN_N*lpn_pkg::LPN_N-1:0]     mul_a;
   logic [lpn_pkg::LPN_N-1:0]                    mul_b;
   logic [lpn_pkg::LPN_N-1:0]                    mul_e;
   logic [lpn_pkg::LPN_N-1:0]                    mul_o;
   logic                                         out_valid;
   logic                                         out_ready;
   logic [lpn_pkg::LPN_N-1:0]                    out_o;

   modport master (
      output in_valid, in_a, in_b, in_e, out_ready, mul_o,
      input  in_ready, mul_a, mul_b, mul_e, out_valid, out_o
   );

   modport slave (
      input  in_valid, in_a, in_b, in_e, out_ready, mul_o,
      output in_ready, mul_a, mul_b, mul_e, out_valid, out_o
   );

endinterface
`default_nettype wire

// File: rtl/lpn_op_regs.sv
`default_nettype none
// ============================================================================
// Module      : lpn_op_regs
// Description : Operand hold register {A, b, e}; updates only when load is set.
// Revision    : 1.0 - initial release
// ============================================================================
module lpn_op_regs #(
   parameter int W = 16640
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] ops_q, ops_d;

   always_comb begin
      ops_d = ops_q;
      if (load) begin
         ops_d = d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ops_q <= '0;
      end else begin
         ops_q <= ops_d;
      end
   end

   assign q = ops_q;

endmodule
`default_nettype wire

// File: rtl/lpn_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lpn_mul_ctrl
// Description : Sequencer for the 2-stage GF(2) 128x128 multiplier (o = A*b ^ e).
//               Optional saturating job counter under LPN_MUL_CTRL_OPCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lpn_mul_ctrl
   import lpn_pkg::*;
#(
   parameter int N = LPN_N
`ifdef LPN_MUL_CTRL_OPCNT_EN
   ,parameter int CNT_W = 32
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   lpn_mul_ctrl_if.slave        bus,
   output logic                 busy
`ifdef LPN_MUL_CTRL_OPCNT_EN
   ,output logic [CNT_W-1:0]    op_cnt
`endif
);

   localparam int OPS_W = N*N + 2*N;

   lpn_state_e       state_q, state_d;
   logic [N-1:0]     out_o_q, out_o_d;
   logic [OPS_W-1:0] ops_q;
   logic             accept;
   logic             out_valid;
   logic             out_fire;

   // clear masks both handshakes in the cycle it is asserted
   assign out_valid    = (state_q == ST_DONE) && !clear;
   assign out_fire     = out_valid && bus.out_ready;
   assign bus.in_ready = !clear && ((state_q == ST_IDLE) ||
                                    ((state_q == ST_DONE) && bus.out_ready));
   assign accept       = bus.in_valid && bus.in_ready;

   lpn_op_regs #(.W(OPS_W)) u_op_regs (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .d     ({bus.in_a, bus.in_b, bus.in_e}),
      .q     (ops_q)
   );

   assign bus.mul_a = ops_q[OPS_W-1 -: N*N];
   assign bus.mul_b = ops_q[2*N-1 -: N];
   assign bus.mul_e = ops_q[N-1:0];

   always_comb begin
      state_d = state_q;
      out_o_d = out_o_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (accept) state_d = ST_EVAL1;
            ST_EVAL1: state_d = ST_EVAL2;
            ST_EVAL2: begin
               out_o_d = bus.mul_o;
               state_d = ST_DONE;
            end
            ST_DONE:  if (bus.out_ready) state_d = accept ? ST_EVAL1 : ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         out_o_q <= '0;
      end else begin
         state_q <= state_d;
         out_o_q <= out_o_d;
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out_o     = out_o_q;
   assign busy          = (state_q != ST_IDLE);

`ifdef LPN_MUL_CTRL_OPCNT_EN
   logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

   always_comb begin
      op_cnt_d = op_cnt_q;
      if (out_fire && (op_cnt_q != {CNT_W{1'b1}})) begin
         op_cnt_d = op_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_cnt_q <= '0;
      end else begin
         op_cnt_q <= op_cnt_d;
      end
   end

   assign op_cnt = op_cnt_q;
`else
   logic unused_fire;
   assign unused_fire = out_fire;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lpn_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpn_mul_ctrl
// Description : Self-checking bench: controller wired to a 2-stage GF(2)
//               multiplier model, vector table plus corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpn_mul_ctrl;

   localparam int N = 128;

   typedef struct {
      logic [N*N-1:0] a;
      logic [N-1:0]   b;
      logic [N-1:0]   e;
      logic [N-1:0]   exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic clear;
   logic busy;
`ifdef LPN_MUL_CTRL_OPCNT_EN
   logic [1:0] op_cnt;
`endif

   lpn_mul_ctrl_if bus ();

`ifdef LPN_MUL_CTRL_OPCNT_EN
   lpn_mul_ctrl #(.N(N), .CNT_W(2)) dut (
      .clk (clk), .reset (reset), .clear (clear), .bus (bus.slave), .busy (busy), .op_cnt (op_cnt)
   );
`else
   lpn_mul_ctrl #(.N(N)) dut (
      .clk (clk), .reset (reset), .clear (clear), .bus (bus.slave), .busy (busy)
   );
`endif

   always #5 clk = ~clk;

   // two-stage multiplier: upper half registered with b[63:0], lower half uses live A
   logic [N-1:0] p1_q;
   logic [63:0]  blo_q;
   logic [N-1:0] mul_o_w;

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         p1_q[i] <= ^(bus.mul_a[i*N+64 +: 64] & bus.mul_b[127:64]);
      end
      blo_q <= bus.mul_b[63:0];
   end

   always_comb begin
      mul_o_w = '0;
      for (int i = 0; i < N; i++) begin
         mul_o_w[i] = p1_q[i] ^ (^(bus.mul_a[i*N +: 64] & blo_q)) ^ bus.mul_e[i];
      end
   end
   assign bus.mul_o = mul_o_w;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   logic [N-1:0] sb_q[$];
   int           acc_q[$];
   logic [N-1:0] exp_next;
   bit           hold = 1'b0;
   vec_t         vecs[8];

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic logic [N-1:0] ref_mul(input logic [N*N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [N-1:0] e);
      logic [N-1:0] o;
      for (int i = 0; i < N; i++) o[i] = (^(a[i*N +: N] & b)) ^ e[i];
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard monitor: push on accept, pop/compare on result handshake
   always @(negedge clk) begin
      if (!reset) begin
         if (clear) begin
            if (busy && sb_q.size() > 0) begin
               void'(sb_q.pop_front());
               void'(acc_q.pop_front());
            end
            hold = 1'b0;
         end else begin
            if (bus.out_valid) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_out_valid", 1, 0);
               end else begin
                  if (!hold) chk("latency", cyc - acc_q[0], 3);
                  if (bus.out_ready) begin
                     chk("out_o", bus.out_o, sb_q.pop_front());
                     void'(acc_q.pop_front());
                     hold = 1'b0;
                  end else begin
                     hold = 1'b1;
                  end
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               sb_q.push_back(exp_next);
               acc_q.push_back(cyc);
            end
         end
      end
   end

   task automatic run_job(input vec_t v);
      int k = 0;
      while (!bus.in_ready && k < 50) begin
         step();
         k++;
      end
      chk("accept_ready", bus.in_ready, 1);
      bus.in_a     = v.a;
      bus.in_b     = v.b;
      bus.in_e     = v.e;
      exp_next     = v.exp;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("busy_eval1", busy, 1);
      chk("mul_a_latched", bus.mul_a == v.a, 1);
   endtask

   task automatic drain();
      int k = 0;
      while (sb_q.size() != 0 && k < 40) begin
         step();
         k++;
      end
      chk("drain", sb_q.size(), 0);
   endtask

   initial begin
      logic [N-1:0] held;
      bit           ok;
      vec_t         v;

      for (int t = 0; t < 8; t++) begin
         vecs[t].a = '0;
         vecs[t].b = '0;
         vecs[t].e = '0;
      end
      vecs[0].b = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
      vecs[0].e = 128'h1;
      vecs[0].exp = 128'h1;
      vecs[1].a[0] = 1'b1;
      vecs[1].a[127*N + 127] = 1'b1;
      vecs[1].b = {1'b1, 126'b0, 1'b1};
      vecs[1].exp = {1'b1, 126'b0, 1'b1};
      for (int i = 0; i < N; i++) begin
         vecs[2].a[i*N + i] = 1'b1;
         vecs[3].a[i*N + i] = 1'b1;
      end
      vecs[2].b = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      vecs[2].exp = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      vecs[3].b = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      vecs[3].e = '1;
      vecs[3].exp = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
      vecs[4].a = '1;
      vecs[4].b = 128'h3;
      vecs[4].e = 128'hF0;
      vecs[4].exp = 128'hF0;
      vecs[5].a = '1;
      vecs[5].b = 128'h7;
      vecs[5].exp = '1;
      for (int t = 6; t < 8; t++) begin
         for (int w = 0; w < N*N/32; w++) vecs[t].a[w*32 +: 32] = $urandom;
         for (int w = 0; w < N/32; w++) begin
            vecs[t].b[w*32 +: 32] = $urandom;
            vecs[t].e[w*32 +: 32] = $urandom;
         end
         vecs[t].exp = ref_mul(vecs[t].a, vecs[t].b, vecs[t].e);
      end

      reset         = 1'b1;
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_e      = '0;
      bus.out_ready = 1'b1;
      exp_next      = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step();

      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_o", bus.out_o, 0);
      chk("rst_mul_b", bus.mul_b, 0);
`ifdef LPN_MUL_CTRL_OPCNT_EN
      chk("rst_op_cnt", op_cnt, 0);
`endif

      for (int t = 0; t < 8; t++) begin
         run_job(vecs[t]);
         drain();
      end

      // result stall for 10 cycles, then back-to-back accept on release
      bus.out_ready = 1'b0;
      v = vecs[0];
      v.e = 128'h5;
      v.exp = 128'h5;
      run_job(v);
      step();
      step();
      chk("stall_valid", bus.out_valid, 1);
      held = bus.out_o;
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (!bus.out_valid || bus.out_o !== held || bus.in_ready) ok = 1'b0;
      end
      chk("stall_hold", ok, 1);
      chk("stall_value", held, 128'h5);
      bus.out_ready = 1'b1;
      bus.in_a      = vecs[2].a;
      bus.in_b      = vecs[2].b;
      bus.in_e      = vecs[2].e;
      exp_next      = vecs[2].exp;
      bus.in_valid  = 1'b1;
      #1;
      chk("b2b_in_ready", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_valid_low", bus.out_valid, 0);
      drain();

      // clear in EVAL2 drops the job
      run_job(vecs[4]);
      step();
      clear = 1'b1;
      #1;
      chk("clear_in_ready", bus.in_ready, 0);
      step();
      clear = 1'b0;
      #1;
      chk("clear_idle", busy, 0);
      chk("clear_in_ready_after", bus.in_ready, 1);
      chk("clear_mul_b_kept", bus.mul_b, vecs[4].b);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (bus.out_valid) ok = 1'b0;
         step();
      end
      chk("clear_no_valid", ok, 1);
      chk("clear_sb_empty", sb_q.size(), 0);
`ifdef LPN_MUL_CTRL_OPCNT_EN
      chk("clear_op_cnt", op_cnt, 3);
`endif
      run_job(vecs[6]);
      drain();

      // asynchronous reset mid-job
      run_job(vecs[5]);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_out_o", bus.out_o, 0);
      chk("arst_mul_b", bus.mul_b, 0);
`ifdef LPN_MUL_CTRL_OPCNT_EN
      chk("arst_op_cnt", op_cnt, 0);
`endif
      sb_q.delete();
      acc_q.delete();
      hold = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("arst_in_ready", bus.in_ready, 1);

      for (int t = 0; t < 5; t++) begin
         run_job(vecs[t]);
         drain();
`ifdef LPN_MUL_CTRL_OPCNT_EN
         chk("op_cnt_sat", op_cnt, (t + 1 < 3) ? t + 1 : 3);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
